// File: rtl/teak_chan_pkg.sv
// Shared types, limits and pointer helper for the Teak channel FIFO.
package teak_chan_pkg;

  localparam int TEAK_FIFO_MAX_DEPTH = 256;
  localparam int TEAK_TOK_WIDTH      = 32;

  typedef logic [TEAK_TOK_WIDTH-1:0] chan_tok_t;

  // Explicit wrap keeps non-power-of-two depths correct.
  function automatic int ptr_inc(input int ptr, input int depth);
    return (ptr >= depth - 1) ? 0 : ptr + 1;
  endfunction

endpackage

// File: rtl/teak_chan_fifo_ctrl.sv
// Pointer, occupancy and handshake control for teak_chan_fifo; storage lives in the top.
module teak_chan_fifo_ctrl
  import teak_chan_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH + 1),
  parameter int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             nReset,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  input  logic             out_ready,
  input  logic             skip_store,
  output logic             in_ready,
  output logic             out_valid,
  output logic [CW-1:0]    count,
  output logic             overflow_err,
  output logic             wr_en,
  output logic [PW-1:0]    wr_idx,
  output logic [PW-1:0]    rd_idx
);

  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [PW-1:0]    wrptr_q;
  logic [PW-1:0]    rdptr_q;
  logic [CW-1:0]    count_q;
  logic [CW-1:0]    count_d;
  logic             in_ready_q;
  logic             out_valid_q;
  logic             stall_q;
  logic [WIDTH-1:0] data_q;
  logic             err_q;
  logic             push;
  logic             pop;
  logic             violation;

  always_comb begin
    push    = in_valid && in_ready_q && !skip_store;
    pop     = out_valid_q && out_ready;
    count_d = count_q;
    if (push && !pop) begin
      count_d = count_q + CW'(1);
    end else if (pop && !push) begin
      count_d = count_q - CW'(1);
    end
    violation = stall_q && (!in_valid || (in_data != data_q));
  end

  // Ready/valid are registered from next occupancy so neither side sees a combinational path.
  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      wrptr_q     <= '0;
      rdptr_q     <= '0;
      count_q     <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      stall_q     <= 1'b0;
      data_q      <= '0;
      err_q       <= 1'b0;
    end else begin
      if (push) begin
        wrptr_q <= PW'(ptr_inc(int'(wrptr_q), DEPTH));
      end
      if (pop) begin
        rdptr_q <= PW'(ptr_inc(int'(rdptr_q), DEPTH));
      end
      count_q     <= count_d;
      in_ready_q  <= (count_d != DEPTH_C);
      out_valid_q <= (count_d != '0);
      stall_q     <= in_valid && !in_ready_q;
      data_q      <= in_data;
      if (violation) begin
        err_q <= 1'b1;
      end
    end
  end

  assign in_ready     = in_ready_q;
  assign out_valid    = out_valid_q;
  assign count        = count_q;
  assign overflow_err = err_q;
  assign wr_en        = push;
  assign wr_idx       = wrptr_q;
  assign rd_idx       = rdptr_q;

endmodule

// File: rtl/teak_chan_fifo.sv
// Elastic valid/ready buffer for one Teak channel with a flop-array store.
// Define TEAK_FIFO_BYPASS_EN for a zero-latency pass-through when the buffer is empty.
module teak_chan_fifo
  import teak_chan_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             nReset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [CW-1:0]    count,
  output logic             overflow_err
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] head;
  logic             wr_en;
  logic [PW-1:0]    wr_idx;
  logic [PW-1:0]    rd_idx;
  logic             ctrl_out_valid;
  logic             skip_store;

  teak_chan_fifo_ctrl #(
    .WIDTH(WIDTH),
    .DEPTH(DEPTH),
    .CW   (CW),
    .PW   (PW)
  ) u_ctrl (
    .clk         (clk),
    .nReset      (nReset),
    .in_valid    (in_valid),
    .in_data     (in_data),
    .out_ready   (out_ready),
    .skip_store  (skip_store),
    .in_ready    (in_ready),
    .out_valid   (ctrl_out_valid),
    .count       (count),
    .overflow_err(overflow_err),
    .wr_en       (wr_en),
    .wr_idx      (wr_idx),
    .rd_idx      (rd_idx)
  );

  // Entries reset to zero so out_data reads 0 out of reset.
  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (wr_en) begin
      mem[wr_idx] <= in_data;
    end
  end

  assign head = mem[rd_idx];

`ifdef TEAK_FIFO_BYPASS_EN
  logic byp_sel;

  assign byp_sel    = (count == '0) && in_valid && in_ready;
  assign skip_store = byp_sel && out_ready;
  assign out_valid  = ctrl_out_valid || byp_sel;
  assign out_data   = byp_sel ? in_data : head;
`else
  assign skip_store = 1'b0;
  assign out_valid  = ctrl_out_valid;
  assign out_data   = head;
`endif

endmodule

// File: tb/tb_teak_chan_fifo.sv
// Self-checking bench for teak_chan_fifo: queue reference model, directed and random traffic.
module tb_teak_chan_fifo;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;

  logic        a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_err;
  logic [31:0] a_in_data, a_out_data;
  logic [2:0]  a_count;

  logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_err;
  logic [31:0] b_in_data, b_out_data;
  logic [1:0]  b_count;

  int compared   = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  teak_chan_fifo #(.WIDTH(32), .DEPTH(4)) dut_a (
    .clk(clk), .nReset(rst_n),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
    .count(a_count), .overflow_err(a_err)
  );

  teak_chan_fifo #(.WIDTH(32), .DEPTH(3)) dut_b (
    .clk(clk), .nReset(rst_n),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
    .count(b_count), .overflow_err(b_err)
  );

  // Reference model for the DEPTH=4 instance: a token queue plus the handshake rules.
  logic [31:0] mq[$];
  bit          m_ready, m_stall, m_err;
  logic [31:0] m_last;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete();
      m_ready = 1'b0;
      m_stall = 1'b0;
      m_err   = 1'b0;
      m_last  = '0;
    end else begin
      bit push, pop, byp;
      byp = 1'b0;
`ifdef TEAK_FIFO_BYPASS_EN
      byp = (mq.size() == 0) && a_in_valid && m_ready && a_out_ready;
`endif
      push = a_in_valid && m_ready && !byp;
      pop  = (mq.size() > 0) && a_out_ready;
      if (m_stall && (!a_in_valid || (a_in_data !== m_last))) m_err = 1'b1;
      m_stall = a_in_valid && !m_ready;
      m_last  = a_in_data;
      if (pop) void'(mq.pop_front());
      if (push) mq.push_back(a_in_data);
      m_ready = (mq.size() < 4);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_a(input string tag);
    logic        ev;
    logic [31:0] ed;
    ev = (mq.size() > 0);
    ed = (mq.size() > 0) ? mq[0] : 32'h0;
`ifdef TEAK_FIFO_BYPASS_EN
    if (mq.size() == 0 && a_in_valid && m_ready) begin
      ev = 1'b1;
      ed = a_in_data;
    end
`endif
    chk({tag, ".in_ready"}, 32'(a_in_ready), 32'(m_ready));
    chk({tag, ".out_valid"}, 32'(a_out_valid), 32'(ev));
    chk({tag, ".count"}, 32'(a_count), 32'(mq.size()));
    chk({tag, ".overflow_err"}, 32'(a_err), 32'(m_err));
    if (ev) chk({tag, ".out_data"}, a_out_data, ed);
  endtask

  task automatic step_a(input logic v, input logic [31:0] d, input logic r, input string tag);
    a_in_valid  = v;
    a_in_data   = d;
    a_out_ready = r;
    @(posedge clk);
    @(negedge clk);
    check_a(tag);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] sq[$];
    int          exp_v;
    bit          acc5;
    bit          held;
    int          nin, nout;

    a_in_valid = 1'b1; a_in_data = 32'hA5A5A5A5; a_out_ready = 1'b0;
    b_in_valid = 1'b0; b_in_data = '0; b_out_ready = 1'b0;
    rst_n = 1'b0;

    // Reset state while the producer is already offering.
    repeat (3) @(negedge clk);
    check_a("reset");
    chk("reset.out_data", a_out_data, 32'h0);
    chk("reset.b_in_ready", 32'(b_in_ready), 32'h0);
    rst_n = 1'b1;
    a_in_valid = 1'b0;
    #1;
    chk("release.in_ready_before_edge", 32'(a_in_ready), 32'h0);
    @(posedge clk);
    @(negedge clk);
    check_a("release");
    chk("release.in_ready", 32'(a_in_ready), 32'h1);

    // Fill to full, a refused fifth token, then drain in order.
    for (int k = 1; k <= 4; k++) step_a(1'b1, 32'(k), 1'b0, "fill");
    chk("fill.count", 32'(a_count), 32'd4);
    chk("fill.in_ready", 32'(a_in_ready), 32'h0);
    step_a(1'b1, 32'd5, 1'b0, "refuse");
    chk("refuse.count", 32'(a_count), 32'd4);
    exp_v = 1;
    acc5  = 1'b0;
    for (int c = 0; c < 20 && exp_v <= 5; c++) begin
      a_out_ready = 1'b1;
      a_in_valid  = !acc5;
      a_in_data   = 32'd5;
      #1;
      if (a_out_valid) begin
        chk("drain.data", a_out_data, 32'(exp_v));
        exp_v++;
      end
      if (a_in_valid && a_in_ready) acc5 = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check_a("drain");
    end
    chk("drain.tokens", 32'(exp_v), 32'd6);
    chk("drain.count", 32'(a_count), 32'd0);

    // Simultaneous push and pop at a steady occupancy of two.
    step_a(1'b1, 32'd100, 1'b0, "pp.prime");
    step_a(1'b1, 32'd101, 1'b0, "pp.prime");
    sq = '{32'd100, 32'd101};
    for (int i = 0; i < 20; i++) begin
      a_in_valid = 1'b1; a_in_data = 32'(200 + i); a_out_ready = 1'b1;
      #1;
      chk("pp.out_data", a_out_data, sq[0]);
      void'(sq.pop_front());
      sq.push_back(32'(200 + i));
      @(posedge clk);
      @(negedge clk);
      check_a("pp");
      chk("pp.count", 32'(a_count), 32'd2);
    end
    step_a(1'b0, 32'h0, 1'b1, "pp.drain");
    step_a(1'b0, 32'h0, 1'b1, "pp.drain");

    // Random legal traffic: a stalled offer is held until accepted.
    held = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (!held) begin
        a_in_valid = 1'($urandom_range(0, 1));
        a_in_data  = $urandom;
      end
      a_out_ready = 1'($urandom_range(0, 1));
      #1;
      held = a_in_valid && !a_in_ready;
      @(posedge clk);
      @(negedge clk);
      check_a("rand");
    end
    for (int i = 0; i < 30 && (held || mq.size() != 0); i++) begin
      if (!held) a_in_valid = 1'b0;
      a_out_ready = 1'b1;
      #1;
      held = a_in_valid && !a_in_ready;
      @(posedge clk);
      @(negedge clk);
      check_a("rand.drain");
    end
    a_in_valid = 1'b0;
    chk("rand.empty", 32'(a_count), 32'd0);

    // Producer changes data while stalled on a full buffer.
    for (int k = 0; k < 4; k++) step_a(1'b1, 32'h1000 + 32'(k), 1'b0, "viol.fill");
    step_a(1'b1, 32'h11, 1'b0, "viol.stall");
    chk("viol.err_before", 32'(a_err), 32'h0);
    step_a(1'b1, 32'h22, 1'b0, "viol.change");
    chk("viol.err_set", 32'(a_err), 32'h1);
    chk("viol.count", 32'(a_count), 32'd4);
    chk("viol.head", a_out_data, 32'h1000);
    step_a(1'b0, 32'h0, 1'b1, "viol.drain");
    step_a(1'b0, 32'h0, 1'b1, "viol.drain");
    chk("viol.err_sticky", 32'(a_err), 32'h1);
    chk("viol.head_after", a_out_data, 32'h1002);

    // Asynchronous reset in mid-cycle with tokens stored.
    #2 rst_n = 1'b0;
    a_in_valid = 1'b0;
    #1;
    chk("midrst.count", 32'(a_count), 32'd0);
    chk("midrst.out_valid", 32'(a_out_valid), 32'h0);
    chk("midrst.in_ready", 32'(a_in_ready), 32'h0);
    chk("midrst.err", 32'(a_err), 32'h0);
    chk("midrst.out_data", a_out_data, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_a("midrst.release");
    step_a(1'b1, 32'h77, 1'b0, "midrst.push");
    chk("midrst.first_token", a_out_data, 32'h77);
    chk("midrst.first_count", 32'(a_count), 32'd1);
    step_a(1'b0, 32'h0, 1'b1, "midrst.pop");

`ifdef TEAK_FIFO_BYPASS_EN
    a_in_valid = 1'b1; a_in_data = 32'h7; a_out_ready = 1'b1;
    #1;
    chk("bypass.out_valid", 32'(a_out_valid), 32'h1);
    chk("bypass.out_data", a_out_data, 32'h7);
    @(posedge clk);
    @(negedge clk);
    a_in_valid = 1'b0;
    #1;
    chk("bypass.count", 32'(a_count), 32'd0);
    chk("bypass.out_valid_after", 32'(a_out_valid), 32'h0);
`endif

    // DEPTH=3 wrap-around with a randomly stalling consumer.
    nin  = 0;
    nout = 0;
    for (int c = 0; c < 200 && nout < 10; c++) begin
      b_in_valid  = (nin < 10);
      b_in_data   = 32'(nin);
      b_out_ready = 1'($urandom_range(0, 1));
      #1;
      if (b_out_valid && b_out_ready) begin
        chk("wrap.order", b_out_data, 32'(nout));
        nout++;
      end
      if (b_in_valid && b_in_ready) nin++;
      @(posedge clk);
      @(negedge clk);
      chk("wrap.count", 32'(b_count), 32'(nin - nout));
    end
    b_in_valid = 1'b0;
    chk("wrap.tokens", 32'(nout), 32'd10);
    chk("wrap.err", 32'(b_err), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/teak_chan_fifo.md
Name: teak_chan_fifo

Overview:
- Clocked elastic buffer for one Teak dataflow channel.
- Sits between two netlist regions built from the gate-level cell library. Decouples a producer's valid/ready handshake from a consumer's, with DEPTH-entry storage.
- The compiler inserts it on channels that need slack: loop back-edges and long fan-out paths.

Parameters:
- WIDTH, 32, data bits per channel token (1..512).
- DEPTH, 4, token storage entries (2..256, need not be a power of two).
- CW, $clog2(DEPTH+1), width of the occupancy count. Derived; do not override.

Ports:
- clk  in  1  sole clock; all state on rising edge.
- nReset  in  1  asynchronous, active-low reset.
- in_valid  in  1  producer offers a token.
- in_ready  out  1  FIFO accepts a token this cycle.
- in_data  in  WIDTH  producer token.
- out_valid  out  1  FIFO offers its head token.
- out_ready  in  1  consumer accepts the head token.
- out_data  out  WIDTH  head token.
- count  out  CW  number of tokens stored.
- overflow_err  out  1  sticky: producer changed in_data or dropped in_valid while stalled.

Behaviour:
- Clock and reset: single clock domain. Reset is asynchronous and active-low: nReset low clears all state immediately, independent of clk.
- Reset values:
  - in_ready=0 while nReset is low; in_ready=1 from the first clk edge after release.
  - out_valid=0, out_data=0, count=0, overflow_err=0.
  - Read and write pointers = 0.
- Handshake transfers:
  - A push occurs on an edge where in_valid&&in_ready.
  - A pop occurs on an edge where out_valid&&out_ready.
- Ready and valid generation:
  - in_ready = !full, registered from state. No combinational path from out_ready.
  - out_valid = !empty, registered.
  - out_data is driven from the registered head entry. No combinational path from in_* to out_*.
- Latency: a token pushed at edge N is visible on out_valid/out_data after edge N, i.e. first poppable at edge N+1. Minimum latency is 1 cycle.
- Throughput: one token per cycle sustained, provided DEPTH>=2 and the consumer is always ready.
- Pointers: wrptr/rdptr increment modulo DEPTH, wrapping explicitly from DEPTH-1 to 0. Comparisons are never based on pointer bits alone.
- count: +1 on push only, -1 on pop only, unchanged on simultaneous push+pop or on neither. full = (count==DEPTH); empty = (count==0).
- Simultaneous push+pop:
  - When empty: only a push is possible (out_valid=0).
  - When full: only a pop is possible (in_ready=0); the freed slot becomes writable on the next cycle.
  - Otherwise both occur; count unchanged, both pointers advance.
- overflow_err:
  - Sets when in_valid was 1 and in_ready was 0 on the previous edge, and on this edge either in_valid==0 or in_data differs from its registered copy.
  - Clears only on reset. Monitoring only; it never alters data flow.
- Reset mid-operation: all stored tokens are discarded; no partial token appears after release.
- Storage: a flop array, not inferred RAM, so the netlist stays technology-mappable.

Optional Feature:
- Macro: TEAK_FIFO_BYPASS_EN.
- Defined: when empty and in_valid=1, in_data flows combinationally to out_data and out_valid=1 in the same cycle.
  - If out_ready=1 the token is consumed without being stored; count stays 0.
  - Latency 0 when empty; other behaviour unchanged.
- Undefined: no combinational in-to-out path; latency is always >=1.

Decomposition:
- Package teak_chan_pkg holds:
  - typedef chan_tok_t (logic [WIDTH-1:0], via a parameterised macro or default width);
  - constant TEAK_FIFO_MAX_DEPTH=256;
  - localparam function ptr_inc(ptr, depth) returning the wrapped increment.
- One natural sub-module: teak_chan_fifo_ctrl. It holds pointers, count, full/empty and overflow_err, and drives write-enable and read-index into the top-level storage array.

Test Plan:
- Reset: hold nReset=0 with in_valid=1 and in_data=0xA5A5A5A5 → in_ready=0, out_valid=0, count=0. Release; after the next edge in_ready=1.
- Fill/drain, DEPTH=4: push 1,2,3,4 with out_ready=0.
  - Required: count=4, in_ready=0, a 5th token is refused.
  - Then out_ready=1: out_data sequence 1,2,3,4; count returns to 0.
- Wrap-around, DEPTH=3: stream 10 tokens 0..9 with random out_ready at 50% → output order 0..9 exactly, count never exceeds 3.
- Simultaneous push+pop at count=2, DEPTH=4, 20 cycles of continuous valid and ready → count stays 2, one token per cycle, order preserved.
- Stall protocol violation: count=4, in_valid=1 with 0x11; next cycle in_data=0x22 → overflow_err=1 and stays 1; stored data is unaffected.
- With TEAK_FIFO_BYPASS_EN, empty FIFO, in_valid=1, in_data=0x7, out_ready=1 → out_valid=1 and out_data=0x7 in the same cycle, count remains 0.
